// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the five-stage pipeline and its control unit:
// per-stage stall requests, multi-cycle EX sequencing and exception flush.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        ex_mc_done;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;

  // Pipeline side: raises requests, consumes stall/flush/redirect.
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
    input  stall, ex_mc_done, flush, new_pc, stall_cycles
  );

  // Control unit side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
    output stall, ex_mc_done, flush, new_pc, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stage stall requests into one stall vector
// (bit0 PC .. bit5 WB, 1 = hold), sequences multi-cycle EX operations,
// turns exception requests into a one-cycle flush plus redirect PC, and
// counts stalled cycles (saturating) for performance monitoring.
module pipe_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_DONE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [31:0] new_pc_r;
  logic [31:0] stall_cycles_r;
  logic        ex_mc_done_r;
  logic        flush_r;

  logic        mc_accept_s;
  logic        req_ex_s;
  logic [5:0]  mc_len_s;
  logic [5:0]  stall_s;

  // A start pulse only counts in RUN; a simultaneous flush kills it.
  always_comb begin
    mc_accept_s = 1'b0;
    if ((state_r == RUN) && bus.ex_mc_start && !bus.flush_req) begin
      mc_accept_s = 1'b1;
    end else begin
      mc_accept_s = 1'b0;
    end
  end

  // Operation length with zero treated as a single cycle.
  always_comb begin
    mc_len_s = bus.ex_mc_cycles;
    if (bus.ex_mc_cycles == 6'd0) begin
      mc_len_s = 6'd1;
    end else begin
      mc_len_s = bus.ex_mc_cycles;
    end
  end

  // EX-level hold: explicit request, a freshly accepted or running MC op.
  always_comb begin
    req_ex_s = 1'b0;
    if (bus.stallreq_ex || mc_accept_s || (state_r == MC_WAIT)) begin
      req_ex_s = 1'b1;
    end else begin
      req_ex_s = 1'b0;
    end
  end

  // Stall vector: flush overrides all, FLUSH state releases all, otherwise
  // the deepest requesting stage wins.
  always_comb begin
    stall_s = 6'b000000;
    if (!rst_n) begin
      stall_s = 6'b000000;
    end else if (bus.flush_req) begin
      stall_s = 6'b111111;
    end else if (state_r == FLUSH) begin
      stall_s = 6'b000000;
    end else if (bus.stallreq_mem) begin
      stall_s = 6'b011111;
    end else if (req_ex_s) begin
      stall_s = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall_s = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall_s = 6'b000011;
    end else begin
      stall_s = 6'b000000;
    end
  end

  // Control FSM with registered done/flush/redirect outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= RUN;
      cnt_r        <= 6'd0;
      new_pc_r     <= 32'd0;
      ex_mc_done_r <= 1'b0;
      flush_r      <= 1'b0;
    end else if (bus.flush_req) begin
      state_r      <= FLUSH;
      cnt_r        <= 6'd0;
      new_pc_r     <= bus.flush_pc;
      ex_mc_done_r <= 1'b0;
      flush_r      <= 1'b1;
    end else begin
      flush_r <= 1'b0;
      case (state_r)
        RUN: begin
          if (mc_accept_s) begin
            cnt_r <= mc_len_s - 6'd1;
            if (mc_len_s == 6'd1) begin
              state_r      <= MC_DONE;
              ex_mc_done_r <= 1'b1;
            end else begin
              state_r      <= MC_WAIT;
              ex_mc_done_r <= 1'b0;
            end
          end else begin
            state_r      <= RUN;
            ex_mc_done_r <= 1'b0;
          end
        end
        MC_WAIT: begin
          // Counts down regardless of other stalls: the unit keeps working.
          cnt_r <= cnt_r - 6'd1;
          if (cnt_r == 6'd1) begin
            state_r      <= MC_DONE;
            ex_mc_done_r <= 1'b1;
          end else begin
            state_r      <= MC_WAIT;
            ex_mc_done_r <= 1'b0;
          end
        end
        MC_DONE: begin
          // Result is consumed only when EX is free to advance.
          if (!stall_s[3]) begin
            state_r      <= RUN;
            ex_mc_done_r <= 1'b0;
          end else begin
            state_r      <= MC_DONE;
            ex_mc_done_r <= 1'b1;
          end
        end
        FLUSH: begin
          state_r      <= RUN;
          ex_mc_done_r <= 1'b0;
        end
        default: begin
          state_r      <= RUN;
          cnt_r        <= 6'd0;
          ex_mc_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any stage was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
    end else if ((stall_s != 6'b000000) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.ex_mc_done   = ex_mc_done_r;
  assign bus.flush        = flush_r;
  assign bus.new_pc       = new_pc_r;
  assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core: merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register, sequences multi-cycle EX operations (divide, multiply-accumulate) by holding the pipe for a programmed cycle count, and converts exception flush requests into a one-cycle `flush` plus redirect PC. It also keeps a saturating count of stalled cycles for performance monitoring.

## Interface
- No parameters; data width 32, stall vector 6 (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop).
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stallreq_if  in  1  instruction bus wait
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  generic EX stall
- stallreq_mem  in  1  data bus wait
- ex_mc_start  in  1  EX requests a multi-cycle operation (one-cycle pulse)
- ex_mc_cycles  in  6  operation length N in cycles (0 treated as 1)
- flush_req  in  1  exception taken
- flush_pc  in  32  exception handler address
- stall  out  6  combinational stall vector
- ex_mc_done  out  1  result valid, EX may advance
- flush  out  1  registered flush of all pipeline registers
- new_pc  out  32  registered redirect address, valid with `flush`
- stall_cycles  out  32  saturating stalled-cycle counter

## Operation
- States: RUN, MC_WAIT, MC_DONE, FLUSH. Registered: state, 6-bit cnt, new_pc, stall_cycles.
- Request masks: if→000011, id→000111, ex (stallreq_ex, ex_mc_start accepted, or state MC_WAIT)→001111, mem→011111. `stall` = highest-stage active mask (mem > ex > id > if); none → 000000.
- flush_req high (any state): stall = 111111 that cycle, overriding all masks; next state FLUSH, new_pc <= flush_pc, cnt <= 0.
- FLUSH: flush = 1, stall = 000000, exactly one cycle, then RUN. flush_req again in FLUSH: re-enter FLUSH with new flush_pc.
- RUN: ex_mc_start accepted only here. cnt <= max(N,1)-1. If N ≤ 1 → MC_DONE; else → MC_WAIT.
- MC_WAIT: cnt decrements every cycle regardless of other stalls; in the cycle cnt == 1 → MC_DONE.
- MC_DONE: ex_mc_done = 1 (Moore). Stall from other requests only. Exit to RUN on first cycle with stall[3] == 0 (EX/MEM accepts result); otherwise hold.
- ex_mc_start outside RUN: ignored. flush_req wins over simultaneous ex_mc_start; MC aborted with no ex_mc_done.
- stall_cycles increments each cycle stall != 0; saturates at FFFF_FFFF. Not incremented during reset.

## Timing
- Reset: state RUN, cnt 0, stall 000000 (forced during reset), ex_mc_done 0, flush 0, new_pc 0, stall_cycles 0. Reset mid-operation aborts MC/FLUSH immediately.
- stall: zero-latency combinational from requests and state.
- Multi-cycle: start cycle = cycle 0 stalled with 001111; total stalled cycles = max(N,1); ex_mc_done high in cycle max(N,1) (unstalled unless MEM/WB stall).
- flush: flush_req at cycle t → flush = 1 and new_pc valid in cycle t+1 only.

## Test plan
- Reset, then stallreq_id=1 and stallreq_mem=1 same cycle → stall = 011111; only stallreq_if → 000011; none → 000000, stall_cycles = 2 after three cycles.
- ex_mc_start with N=4 at cycle 0 → stall = 001111 cycles 0–3, ex_mc_done = 1 cycle 4, stall = 0 cycle 4; N=0 and N=1 → one stalled cycle, done cycle 1.
- N=3, stallreq_mem held cycles 2–5 → ex_mc_done asserted from cycle 3 and held until cycle 6 (first stall[3]==0), then RUN.
- flush_req with flush_pc=0x0000_0040 during MC_WAIT → stall = 111111 that cycle, next cycle flush=1, new_pc=0x40, stall=0; ex_mc_done never asserted.
- flush_req and ex_mc_start same cycle → flush sequence only; second ex_mc_start in MC_WAIT ignored (done timing unchanged).
- Preload-equivalent: run 2^32+ stalled cycles (or force counter to FFFF_FFFE) → stall_cycles sticks at FFFF_FFFF; rst_n low mid-MC → all outputs reset next edge.
